// File: rtl/ct_mmu_dutlb_refill_if.sv
// jTLB request/response channel for the dutlb refill controller.
// master: utlb side (req/vpn out, ack/refill in); slave: jtlb side.
interface ct_mmu_dutlb_refill_if #(
  parameter int VPN_WIDTH = 27,
  parameter int PPN_WIDTH = 28,
  parameter int FLG_WIDTH = 14
);
  logic                 utlb_jtlb_req;
  logic [VPN_WIDTH-1:0] utlb_jtlb_vpn;
  logic                 jtlb_utlb_ack;
  logic                 jtlb_utlb_refill_vld;
  logic                 jtlb_utlb_refill_fault;
  logic [PPN_WIDTH-1:0] jtlb_utlb_ppn;
  logic [FLG_WIDTH-1:0] jtlb_utlb_flg;

  modport master (
    output utlb_jtlb_req,
    output utlb_jtlb_vpn,
    input  jtlb_utlb_ack,
    input  jtlb_utlb_refill_vld,
    input  jtlb_utlb_refill_fault,
    input  jtlb_utlb_ppn,
    input  jtlb_utlb_flg
  );

  modport slave (
    input  utlb_jtlb_req,
    input  utlb_jtlb_vpn,
    output jtlb_utlb_ack,
    output jtlb_utlb_refill_vld,
    output jtlb_utlb_refill_fault,
    output jtlb_utlb_ppn,
    output jtlb_utlb_flg
  );
endinterface

// File: rtl/ct_mmu_dutlb_refill.sv
// Data uTLB refill controller: miss -> jTLB request -> victim write.
// Ports: utlb_clk/cpurst_b, LSU miss, clears, entry valids, jtlb channel, entry update bus, status pulses.
module ct_mmu_dutlb_refill #(
  parameter int ENTRY_NUM = 17,
  parameter int VPN_WIDTH = 27,
  parameter int PPN_WIDTH = 28,
  parameter int FLG_WIDTH = 14
) (
  input  logic                 utlb_clk,
  input  logic                 cpurst_b,
  input  logic                 lsu_utlb_miss_vld,
  input  logic [VPN_WIDTH-1:0] lsu_utlb_miss_vpn,
  input  logic                 regs_utlb_clr,
  input  logic                 tlboper_utlb_clr,
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld,
  ct_mmu_dutlb_refill_if.master jtlb,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
  output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
  output logic [FLG_WIDTH-1:0] utlb_upd_flg,
  output logic                 utlb_refill_busy,
  output logic                 utlb_refill_done,
  output logic                 utlb_refill_fault
);

  localparam int PW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [VPN_WIDTH-1:0] vpn_q;
  logic [PPN_WIDTH-1:0] ppn_q;
  logic [FLG_WIDTH-1:0] flg_q;
  logic [PW-1:0]        rr_ptr;
  logic                 fault_q;

  logic                 clr;
  logic                 vpn_ld;
  logic                 data_ld;
  logic                 fault_set;
  logic                 wr_en;
  logic                 vic_free;
  logic [PW-1:0]        vic_idx;
  logic [PW-1:0]        rr_nxt;

  assign clr = regs_utlb_clr | tlboper_utlb_clr;

  always_comb begin
    state_nxt = state;
    vpn_ld    = 1'b0;
    data_ld   = 1'b0;
    fault_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu_utlb_miss_vld && !clr) begin
          vpn_ld    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (clr)
          state_nxt = IDLE;
        else if (jtlb.jtlb_utlb_ack)
          state_nxt = WAIT;
      end
      WAIT: begin
        // A response landing with the clear is consumed here,
        // so there is nothing left to drop.
        if (clr) begin
          state_nxt = jtlb.jtlb_utlb_refill_vld ? IDLE : DROP;
        end else if (jtlb.jtlb_utlb_refill_vld) begin
          if (jtlb.jtlb_utlb_refill_fault) begin
            fault_set = 1'b1;
            state_nxt = IDLE;
          end else begin
            data_ld   = 1'b1;
            state_nxt = WRITE;
          end
        end
      end
      DROP: begin
        if (jtlb.jtlb_utlb_refill_vld)
          state_nxt = IDLE;
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Lowest free slot wins; rr_ptr only when the uTLB is full.
  always_comb begin
    vic_free = 1'b0;
    vic_idx  = rr_ptr;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!utlb_entry_vld[i]) begin
        vic_free = 1'b1;
        vic_idx  = PW'(i);
      end
    end
  end

  assign rr_nxt = (rr_ptr == PW'(ENTRY_NUM - 1)) ? '0 : rr_ptr + 1'b1;
  assign wr_en  = (state == WRITE) && !clr;

  always_ff @(posedge utlb_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= IDLE;
      vpn_q   <= '0;
      ppn_q   <= '0;
      flg_q   <= '0;
      rr_ptr  <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      fault_q <= fault_set;
      if (vpn_ld)
        vpn_q <= lsu_utlb_miss_vpn;
      if (data_ld) begin
        ppn_q <= jtlb.jtlb_utlb_ppn;
        flg_q <= jtlb.jtlb_utlb_flg;
      end
      if (wr_en && !vic_free)
        rr_ptr <= rr_nxt;
    end
  end

  assign jtlb.utlb_jtlb_req = (state == REQ);
  assign jtlb.utlb_jtlb_vpn = vpn_q;

  assign utlb_entry_upd    = wr_en ? (ENTRY_NUM'(1) << vic_idx) : '0;
  assign utlb_upd_vpn      = vpn_q;
  assign utlb_upd_ppn      = ppn_q;
  assign utlb_upd_flg      = flg_q;
  assign utlb_refill_busy  = (state != IDLE);
  assign utlb_refill_done  = wr_en;
  assign utlb_refill_fault = fault_q;

endmodule

// File: tb/tb_ct_mmu_dutlb_refill.sv
// Randomized self-checking bench for ct_mmu_dutlb_refill.
// Reference: entry-valid array + round-robin counter model.
module tb_ct_mmu_dutlb_refill;

  localparam int EN = 17;
  localparam int VW = 27;
  localparam int PW = 28;
  localparam int FW = 14;

  logic          utlb_clk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          miss_vld = 1'b0;
  logic [VW-1:0] miss_vpn = '0;
  logic          regs_clr = 1'b0;
  logic          oper_clr = 1'b0;
  logic [EN-1:0] ev = '0;
  logic [EN-1:0] upd;
  logic [VW-1:0] upd_vpn;
  logic [PW-1:0] upd_ppn;
  logic [FW-1:0] upd_flg;
  logic          busy;
  logic          done;
  logic          fault;

  int passed = 0;
  int total  = 0;
  int mdl_rr = 0;

  ct_mmu_dutlb_refill_if #(
    .VPN_WIDTH(VW), .PPN_WIDTH(PW), .FLG_WIDTH(FW)
  ) jif ();

  ct_mmu_dutlb_refill #(
    .ENTRY_NUM(EN), .VPN_WIDTH(VW),
    .PPN_WIDTH(PW), .FLG_WIDTH(FW)
  ) dut (
    .utlb_clk          (utlb_clk),
    .cpurst_b          (cpurst_b),
    .lsu_utlb_miss_vld (miss_vld),
    .lsu_utlb_miss_vpn (miss_vpn),
    .regs_utlb_clr     (regs_clr),
    .tlboper_utlb_clr  (oper_clr),
    .utlb_entry_vld    (ev),
    .jtlb              (jif.master),
    .utlb_entry_upd    (upd),
    .utlb_upd_vpn      (upd_vpn),
    .utlb_upd_ppn      (upd_ppn),
    .utlb_upd_flg      (upd_flg),
    .utlb_refill_busy  (busy),
    .utlb_refill_done  (done),
    .utlb_refill_fault (fault)
  );

  always #5 utlb_clk = ~utlb_clk;

  initial begin
    jif.jtlb_utlb_ack          = 1'b0;
    jif.jtlb_utlb_refill_vld   = 1'b0;
    jif.jtlb_utlb_refill_fault = 1'b0;
    jif.jtlb_utlb_ppn          = '0;
    jif.jtlb_utlb_flg          = '0;
  end

  task automatic nxt();
    @(posedge utlb_clk);
    #1;
  endtask

  function automatic int ref_victim();
    for (int i = 0; i < EN; i++)
      if (!ev[i]) return i;
    return mdl_rr;
  endfunction

  // Full refill; clr_wr raises a clear during the write cycle.
  task automatic run_refill(
    input string         nm,
    input logic [VW-1:0] vpn,
    input logic [PW-1:0] ppn,
    input logic [FW-1:0] flg,
    input int            ackd,
    input int            rspd,
    input bit            clr_wr
  );
    int            v;
    logic [EN-1:0] exp_upd;
    nxt();
    miss_vld = 1'b1;
    miss_vpn = vpn;
    nxt();
    miss_vld = 1'b0;
    miss_vpn = VW'($urandom);
    for (int i = 0; i < ackd; i++) begin
      @(negedge utlb_clk);
      nxt();
    end
    jif.jtlb_utlb_ack = 1'b1;
    @(negedge utlb_clk);
    total++;
    if (jif.utlb_jtlb_req !== 1'b1 || jif.utlb_jtlb_vpn !== vpn)
      $display("FAIL %s req: got %b/%h want 1/%h",
               nm, jif.utlb_jtlb_req, jif.utlb_jtlb_vpn, vpn);
    else passed++;
    nxt();
    jif.jtlb_utlb_ack = 1'b0;
    for (int i = 0; i < rspd; i++) begin
      miss_vld = 1'($urandom);
      miss_vpn = VW'($urandom);
      @(negedge utlb_clk);
      nxt();
    end
    miss_vld = 1'b0;
    @(negedge utlb_clk);
    total++;
    if (jif.utlb_jtlb_req !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s wait: req/busy got %b/%b want 0/1",
               nm, jif.utlb_jtlb_req, busy);
    else passed++;
    nxt();
    jif.jtlb_utlb_refill_vld = 1'b1;
    jif.jtlb_utlb_ppn = ppn;
    jif.jtlb_utlb_flg = flg;
    nxt();
    jif.jtlb_utlb_refill_vld = 1'b0;
    jif.jtlb_utlb_ppn = PW'($urandom);
    jif.jtlb_utlb_flg = FW'($urandom);
    regs_clr = clr_wr & 1'($urandom);
    oper_clr = clr_wr & !regs_clr;
    v = ref_victim();
    exp_upd = clr_wr ? '0 : (EN'(1) << v);
    @(negedge utlb_clk);
    total++;
    if (upd !== exp_upd || done !== !clr_wr || busy !== 1'b1)
      $display("FAIL %s write: upd/done/busy got %h/%b/%b want %h/%b/1",
               nm, upd, done, busy, exp_upd, !clr_wr);
    else passed++;
    if (!clr_wr) begin
      total++;
      if (upd_vpn !== vpn || upd_ppn !== ppn || upd_flg !== flg)
        $display("FAIL %s data: got %h/%h/%h want %h/%h/%h",
                 nm, upd_vpn, upd_ppn, upd_flg, vpn, ppn, flg);
      else passed++;
      if (&ev) mdl_rr = (mdl_rr + 1) % EN;
    end
    nxt();
    regs_clr = 1'b0;
    oper_clr = 1'b0;
    if (!clr_wr) ev[v] = 1'b1;
    @(negedge utlb_clk);
    total++;
    if (busy !== 1'b0 || upd !== '0 || done !== 1'b0 || fault !== 1'b0)
      $display("FAIL %s after: busy/upd/done/fault got %b/%h/%b/%b want 0",
               nm, busy, upd, done, fault);
    else passed++;
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0;
    #12;
    total++;
    if (busy !== 0 || upd !== '0 || done !== 0 || fault !== 0 ||
        jif.utlb_jtlb_req !== 0 || jif.utlb_jtlb_vpn !== '0 ||
        upd_vpn !== '0 || upd_ppn !== '0 || upd_flg !== '0)
      $display("FAIL reset: busy %b upd %h done %b fault %b req %b",
               busy, upd, done, fault, jif.utlb_jtlb_req);
    else passed++;
    @(negedge utlb_clk);
    cpurst_b = 1'b1;
    mdl_rr = 0;
  endtask

  task automatic test_basic();
    ev = '0;
    run_refill("basic", VW'('h1234), PW'('hABCDE), FW'('h0155), 0, 0, 1'b0);
  endtask

  task automatic test_round_robin();
    ev = '1;
    for (int k = 0; k < 18; k++) begin
      total++;
      if (mdl_rr !== (k % EN))
        $display("FAIL rr_model: got %0d want %0d", mdl_rr, k % EN);
      else passed++;
      run_refill("rr", VW'($urandom), PW'($urandom), FW'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
  endtask

  task automatic test_fault();
    nxt();
    miss_vld = 1'b1;
    miss_vpn = VW'($urandom);
    nxt();
    miss_vld = 1'b0;
    jif.jtlb_utlb_ack = 1'b1;
    nxt();
    jif.jtlb_utlb_ack = 1'b0;
    jif.jtlb_utlb_refill_vld = 1'b1;
    jif.jtlb_utlb_refill_fault = 1'b1;
    nxt();
    jif.jtlb_utlb_refill_vld = 1'b0;
    jif.jtlb_utlb_refill_fault = 1'b0;
    @(negedge utlb_clk);
    total++;
    if (fault !== 1 || upd !== '0 || done !== 0 || busy !== 0)
      $display("FAIL fault_pulse: fault/upd/done/busy got %b/%h/%b/%b want 1/0/0/0",
               fault, upd, done, busy);
    else passed++;
    nxt();
    @(negedge utlb_clk);
    total++;
    if (fault !== 0 || busy !== 0)
      $display("FAIL fault_len: fault/busy got %b/%b want 0/0", fault, busy);
    else passed++;
  endtask

  task automatic test_clr_wait();
    logic [VW-1:0] v2;
    v2 = VW'($urandom);
    nxt();
    miss_vld = 1'b1;
    miss_vpn = VW'($urandom);
    nxt();
    miss_vld = 1'b0;
    jif.jtlb_utlb_ack = 1'b1;
    nxt();
    jif.jtlb_utlb_ack = 1'b0;
    nxt();
    oper_clr = 1'b1;
    nxt();
    oper_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      jif.jtlb_utlb_refill_vld = (i == 2);
      jif.jtlb_utlb_ppn = PW'($urandom);
      @(negedge utlb_clk);
      total++;
      if (busy !== 1 || upd !== '0 || done !== 0 || fault !== 0)
        $display("FAIL drop_%0d: busy/upd/done/fault got %b/%h/%b/%b want 1/0/0/0",
                 i, busy, upd, done, fault);
      else passed++;
      nxt();
    end
    jif.jtlb_utlb_refill_vld = 1'b0;
    miss_vld = 1'b1;
    miss_vpn = v2;
    @(negedge utlb_clk);
    total++;
    if (busy !== 0 || upd !== '0 || done !== 0)
      $display("FAIL drop_idle: busy/upd/done got %b/%h/%b want 0/0/0",
               busy, upd, done);
    else passed++;
    nxt();
    miss_vld = 1'b0;
    @(negedge utlb_clk);
    total++;
    if (jif.utlb_jtlb_req !== 1 || jif.utlb_jtlb_vpn !== v2)
      $display("FAIL drop_newmiss: req/vpn got %b/%h want 1/%h",
               jif.utlb_jtlb_req, jif.utlb_jtlb_vpn, v2);
    else passed++;
    oper_clr = 1'b1;
    nxt();
    oper_clr = 1'b0;
  endtask

  task automatic test_simultaneous();
    nxt();
    miss_vld = 1'b1;
    miss_vpn = VW'($urandom);
    nxt();
    miss_vld = 1'b0;
    jif.jtlb_utlb_ack = 1'b1;
    regs_clr = 1'b1;
    nxt();
    jif.jtlb_utlb_ack = 1'b0;
    regs_clr = 1'b0;
    jif.jtlb_utlb_refill_vld = 1'b1;
    @(negedge utlb_clk);
    total++;
    if (busy !== 0 || jif.utlb_jtlb_req !== 0)
      $display("FAIL clr_ack: busy/req got %b/%b want 0/0",
               busy, jif.utlb_jtlb_req);
    else passed++;
    nxt();
    jif.jtlb_utlb_refill_vld = 1'b0;
    @(negedge utlb_clk);
    total++;
    if (busy !== 0 || upd !== '0 || done !== 0)
      $display("FAIL clr_ack_late: busy/upd/done got %b/%h/%b want 0",
               busy, upd, done);
    else passed++;
    ev = '1;
    run_refill("clr_wr", VW'($urandom), PW'($urandom), FW'($urandom),
               0, 1, 1'b1);
    run_refill("post_clr", VW'($urandom), PW'($urandom), FW'($urandom),
               1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) ev = '1;
      else ev = EN'($urandom);
      run_refill("rand", VW'($urandom), PW'($urandom), FW'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_reset_mid_wait();
    nxt();
    miss_vld = 1'b1;
    miss_vpn = VW'($urandom | 1);
    nxt();
    miss_vld = 1'b0;
    jif.jtlb_utlb_ack = 1'b1;
    nxt();
    jif.jtlb_utlb_ack = 1'b0;
    nxt();
    cpurst_b = 1'b0;
    #1;
    total++;
    if (busy !== 0 || jif.utlb_jtlb_req !== 0 || jif.utlb_jtlb_vpn !== '0 ||
        upd !== '0 || done !== 0 || fault !== 0)
      $display("FAIL rst_wait: busy %b req %b vpn %h upd %h",
               busy, jif.utlb_jtlb_req, jif.utlb_jtlb_vpn, upd);
    else passed++;
    mdl_rr = 0;
    nxt();
    cpurst_b = 1'b1;
    ev = '0;
    jif.jtlb_utlb_refill_vld = 1'b1;
    nxt();
    jif.jtlb_utlb_refill_vld = 1'b0;
    @(negedge utlb_clk);
    total++;
    if (busy !== 0 || upd !== '0 || done !== 0)
      $display("FAIL rst_late_rsp: busy/upd/done got %b/%h/%b want 0",
               busy, upd, done);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_fault();
    test_clr_wait();
    test_simultaneous();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
